// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with req/ack data bus, stall and registered writeback
module mem_access_unit #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemWrite,
  input  logic        MEM_LW,
  input  logic        MEM_RegWrite,
  input  logic [1:0]  MEM_DatatoReg,
  input  logic [4:0]  MEM_Rdes,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_RDataB,
  input  logic [31:0] MEM_PCFour,
  input  logic [31:0] MEM_LuiData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_stall,
  output logic        WB_RegWrite,
  output logic [4:0]  WB_Rdes,
  output logic [31:0] WB_Data,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Last WAIT cycle index that may still end in a timeout (counter starts at 0).
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        acc, aligned, misaligned;
  logic        start, ack_hit, timeout_hit;
  logic [7:0]  wait_cnt;
  logic [31:0] load_buf;
  logic        timeout_flag;
  logic [31:0] wb_sel;

  assign acc        = MEM_LW | MEM_MemWrite;
  assign aligned    = (MEM_ALUOut[1:0] == 2'b00);
  assign misaligned = acc & ~aligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    mem_stall   = 1'b0;
    case (state)
      IDLE: begin
        if (acc && aligned) begin
          start     = 1'b1;
          mem_stall = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (wait_cnt >= WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      wait_cnt     <= 8'h0;
      load_buf     <= 32'h0;
      timeout_flag <= 1'b0;
      bus_err      <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      bus_err   <= timeout_hit;
      align_err <= (state == IDLE) & misaligned;
      if (start) begin
        mem_req      <= 1'b1;
        mem_we       <= MEM_MemWrite;
        mem_addr     <= {MEM_ALUOut[31:2], 2'b00};
        mem_wdata    <= MEM_RDataB;
        wait_cnt     <= 8'h0;
        timeout_flag <= 1'b0;
      end else if (state == WAIT) begin
        if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'h1;
        if (ack_hit) begin
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
          load_buf <= mem_rdata;
        end else if (timeout_hit) begin
          mem_req      <= 1'b0;
          mem_we       <= 1'b0;
          load_buf     <= ERR_DATA;
          timeout_flag <= 1'b1;
        end
      end else if (state == DONE) begin
        // The flag has already gated the DONE-edge writeback; clear it for the next instruction.
        timeout_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    wb_sel = MEM_ALUOut;
    case (MEM_DatatoReg)
      2'b00: wb_sel = MEM_ALUOut;
      2'b01: wb_sel = load_buf;
      2'b10: wb_sel = MEM_PCFour;
      2'b11: wb_sel = MEM_LuiData;
      default: wb_sel = MEM_ALUOut;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WB_RegWrite <= 1'b0;
      WB_Rdes     <= 5'h0;
      WB_Data     <= 32'h0;
    end else if (!mem_stall) begin
      WB_RegWrite <= MEM_RegWrite & ~misaligned & ~timeout_flag;
      WB_Rdes     <= MEM_Rdes;
      WB_Data     <= wb_sel;
    end else begin
      WB_RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit against a per-instruction model
module tb_mem_access_unit;

  localparam int          TIMEOUT_P = 4;
  localparam logic [31:0] ERR_P     = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_MemWrite, MEM_LW, MEM_RegWrite;
  logic [1:0]  MEM_DatatoReg;
  logic [4:0]  MEM_Rdes;
  logic [31:0] MEM_ALUOut, MEM_RDataB, MEM_PCFour, MEM_LuiData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, mem_stall;
  logic        WB_RegWrite;
  logic [4:0]  WB_Rdes;
  logic [31:0] WB_Data;
  logic        align_err, bus_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] lb_model = 32'h0;

  mem_access_unit #(.TIMEOUT(TIMEOUT_P), .ERR_DATA(ERR_P)) dut (
    .clk(clk), .rst(rst),
    .MEM_MemWrite(MEM_MemWrite), .MEM_LW(MEM_LW), .MEM_RegWrite(MEM_RegWrite),
    .MEM_DatatoReg(MEM_DatatoReg), .MEM_Rdes(MEM_Rdes), .MEM_ALUOut(MEM_ALUOut),
    .MEM_RDataB(MEM_RDataB), .MEM_PCFour(MEM_PCFour), .MEM_LuiData(MEM_LuiData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
    .WB_RegWrite(WB_RegWrite), .WB_Rdes(WB_Rdes), .WB_Data(WB_Data),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    MEM_MemWrite = 0; MEM_LW = 0; MEM_RegWrite = 0; MEM_DatatoReg = 0; MEM_Rdes = 0;
    MEM_ALUOut = 0; MEM_RDataB = 0; MEM_PCFour = 0; MEM_LuiData = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wb_rw"}, WB_RegWrite, 0);
    chk({tag, "_wb_rd"}, WB_Rdes, 0);
    chk({tag, "_wb_data"}, WB_Data, 0);
    chk({tag, "_align"}, align_err, 0);
    chk({tag, "_buserr"}, bus_err, 0);
  endtask

  // Presents one instruction in MEM, plays the bus (ack on WAIT cycle ack_delay) until the
  // stage advances, then checks the writeback against what the rules predict.
  // Entered and left 1 time unit after a rising edge.
  task automatic run_instr(input logic lw, input logic sw, input logic rw, input logic [1:0] dtr,
                           input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] bdata,
                           input logic [31:0] pc4, input logic [31:0] lui, input logic [31:0] rdata,
                           input int ack_delay);
    logic        is_acc, is_mis, is_to, st, saw_bus_err;
    int          exp_waits, stalls, waits, first_req, cyc;
    logic [31:0] exp_data, junk;
    MEM_LW = lw; MEM_MemWrite = sw; MEM_RegWrite = rw; MEM_DatatoReg = dtr; MEM_Rdes = rd;
    MEM_ALUOut = alu; MEM_RDataB = bdata; MEM_PCFour = pc4; MEM_LuiData = lui;
    mem_ack = 0;

    is_acc    = (lw | sw) && (alu % 4 == 0);
    is_mis    = (lw | sw) && (alu % 4 != 0);
    is_to     = is_acc && (ack_delay > TIMEOUT_P);
    exp_waits = !is_acc ? 0 : (is_to ? TIMEOUT_P : ack_delay);
    if (is_acc) lb_model = is_to ? ERR_P : rdata;
    case (dtr)
      2'd0: exp_data = alu;
      2'd1: exp_data = lb_model;
      2'd2: exp_data = pc4;
      default: exp_data = lui;
    endcase

    stalls = 0; waits = 0; first_req = -1; cyc = 0; saw_bus_err = 0;
    do begin
      @(negedge clk);
      st = mem_stall;
      saw_bus_err = bus_err;
      if (mem_req) begin
        if (first_req < 0) first_req = cyc;
        waits++;
        chk("bus_addr", mem_addr, alu);
        chk("bus_we", mem_we, sw);
        chk("bus_wdata", mem_wdata, bdata);
      end
      junk = $urandom;
      if (mem_req) begin
        mem_ack   = (waits == ack_delay);
        mem_rdata = mem_ack ? rdata : junk;
      end else begin
        // stray acks outside WAIT must be ignored
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = junk;
      end
      if (st) stalls++;
      @(posedge clk);
      #1;
      mem_ack = 0;
      cyc++;
    end while (st && cyc < 300);

    chk("stall_cycles", stalls, exp_waits + (is_acc ? 1 : 0));
    chk("wait_cycles", waits, exp_waits);
    if (is_acc) chk("req_rise_cycle", first_req, 1);
    chk("bus_err", saw_bus_err, is_to);
    chk("align_err", align_err, is_mis);
    chk("req_after", mem_req, 0);
    chk("wb_regwrite", WB_RegWrite, rw & ~is_mis & ~is_to);
    chk("wb_rdes", WB_Rdes, rd);
    chk("wb_data", WB_Data, exp_data);
  endtask

  initial begin
    logic [31:0] a, r;
    logic [1:0]  kind;
    clear_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    chk("por_stall", mem_stall, 0);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1;

    // Reset in the middle of WAIT
    MEM_LW = 1; MEM_RegWrite = 1; MEM_DatatoReg = 2'b01; MEM_Rdes = 5'd9; MEM_ALUOut = 32'h200;
    @(posedge clk);
    #1;
    chk("wait_req", mem_req, 1);
    #2 rst = 0;
    #1;
    chk_reset_state("midrst");
    clear_inputs();
    @(negedge clk) rst = 1;
    mem_ack = 1; mem_rdata = 32'h5555AAAA;
    @(posedge clk);
    #1;
    mem_ack = 0;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_stall", mem_stall, 0);
    chk("late_ack_wbrw", WB_RegWrite, 0);
    lb_model = 32'h0;

    // Directed cases
    run_instr(1, 0, 1, 2'b01, 5'd5, 32'h100, 32'h0, 32'h0, 32'h0, 32'h12345678, 1);
    run_instr(0, 1, 0, 2'b00, 5'd0, 32'h40, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 3);
    run_instr(1, 0, 1, 2'b01, 5'd7, 32'h102, 32'h0, 32'h0, 32'h0, 32'h11111111, 1);
    run_instr(1, 0, 1, 2'b01, 5'd8, 32'h80, 32'h0, 32'h0, 32'h0, 32'h22222222, 10);
    run_instr(0, 0, 1, 2'b00, 5'd3, 32'h7, 32'h0, 32'h0, 32'h0, 32'h0, 1);
    run_instr(1, 0, 1, 2'b01, 5'd10, 32'h300, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5, 1);
    run_instr(1, 0, 1, 2'b01, 5'd11, 32'h304, 32'h0, 32'h0, 32'h0, 32'h5A5A5A5A, 2);
    run_instr(1, 1, 1, 2'b10, 5'd12, 32'h308, 32'h77, 32'h1000, 32'h0, 32'h0, TIMEOUT_P);
    run_instr(0, 0, 1, 2'b11, 5'd13, 32'h1, 32'h0, 32'h0, 32'hABCD0000, 32'h0, 1);

    // Randomized instruction stream
    for (int i = 0; i < 120; i++) begin
      kind = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      else if (a[1:0] == 2'b00) a[0] = 1'b1;
      r = $urandom;
      run_instr(kind[0], kind[1], 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 31)), a, $urandom, $urandom, $urandom, r,
                $urandom_range(1, TIMEOUT_P + 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage consumer of the EXE/MEM pipeline latch outputs. Executes loads and stores against a word-wide data-memory bus with a req/ack handshake. Holds the front of the pipeline with `mem_stall` while a bus access is outstanding, then hands a registered result to the writeback stage. Misaligned accesses and bus timeouts are detected and suppress the register write.

## Interface
- `TIMEOUT`, default 16: maximum WAIT cycles without `mem_ack` before the access is abandoned (range 1–255).
- `ERR_DATA`, default 32'hDEADBEEF: load data returned on a timeout.

Ports:
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  reset; asynchronous, active-low.
- `MEM_MemWrite`  input  1  store request.
- `MEM_LW`  input  1  load request.
- `MEM_RegWrite`  input  1  instruction writes a register.
- `MEM_DatatoReg`  input  2  writeback source: 00 ALUOut, 01 load data, 10 PCFour, 11 LuiData.
- `MEM_Rdes`  input  5  destination register.
- `MEM_ALUOut`  input  32  effective address / ALU result.
- `MEM_RDataB`  input  32  store data.
- `MEM_PCFour`  input  32  return address.
- `MEM_LuiData`  input  32  LUI result.
- `mem_req`  output  1  bus request, registered.
- `mem_we`  output  1  bus write enable, valid with `mem_req`.
- `mem_addr`  output  32  word address (bits [1:0] always 0).
- `mem_wdata`  output  32  store data.
- `mem_rdata`  input  32  load data, valid with `mem_ack`.
- `mem_ack`  input  1  bus completion.
- `mem_stall`  output  1  combinational; freezes IF/ID/EXE and the EXE/MEM latch.
- `WB_RegWrite`  output  1  registered writeback enable.
- `WB_Rdes`  output  5  registered destination.
- `WB_Data`  output  32  registered writeback value.
- `align_err`  output  1  one-cycle pulse, misaligned access.
- `bus_err`  output  1  one-cycle pulse, bus timeout.

## Operation
- An access is `acc = MEM_LW | MEM_MemWrite`. It is aligned when `MEM_ALUOut[1:0] == 0`. If both `MEM_LW` and `MEM_MemWrite` are set, the store takes priority.
- The FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - If `acc` and aligned: latch address, write data and we into bus registers; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - `mem_req`=1 throughout.
  - On `mem_ack`: capture `mem_rdata` into the load buffer and go to DONE.
  - If the wait counter reaches `TIMEOUT` without an ack: load buffer ← `ERR_DATA`, set the err flag, go to DONE.
- DONE: go to IDLE unconditionally.
- `mem_stall = (IDLE & acc & aligned) | WAIT`. It is 0 in DONE, so the latch advances on the DONE edge.
- WB registers load on every clock edge where `mem_stall`=0:
  - `WB_Rdes` ← `MEM_Rdes`.
  - `WB_Data` is selected by `MEM_DatatoReg`; source 01 takes the load buffer.
  - `WB_RegWrite` ← `MEM_RegWrite & ~misaligned & ~timeout_flag`.
- While `mem_stall`=1, the WB registers load a bubble: `WB_RegWrite`=0, other WB fields hold.
- Misaligned access:
  - No bus activity and no stall.
  - `align_err` pulses on the next cycle.
  - The register write is suppressed.
- `bus_err` pulses for one cycle, on the edge that enters DONE via timeout.
- The wait counter is 8 bits, clears on entry to WAIT and saturates; no wrap.
- `mem_ack` outside WAIT is ignored.

## Timing
- Reset (`rst`=0) immediately forces:
  - State IDLE.
  - `mem_req`, `mem_we`, `WB_RegWrite`, `align_err`, `bus_err` = 0.
  - `mem_addr`, `mem_wdata`, `WB_Data`, load buffer = 0; `WB_Rdes` = 0; counter = 0.
- Reset mid-WAIT drops `mem_req` asynchronously and abandons the access; a late `mem_ack` is ignored.
- Non-memory instruction: 1 cycle in MEM, 0 stall.
- Aligned access with ack on the first WAIT cycle:
  - Cycle 0 (IDLE): stall.
  - Cycle 1 (WAIT): `mem_req`, stall.
  - Cycle 2 (DONE): no stall.
  - WB valid after the cycle-2 edge.
  - Total: 2 stall cycles; each extra ack wait adds 1.
- Timeout: exactly `TIMEOUT` WAIT cycles, then DONE.
- `mem_req` deasserts on the edge after `mem_ack`. Address and data are stable for the whole WAIT.
- Back-to-back accesses: the second enters IDLE on the DONE edge and requests one cycle later. There is no IDLE gap beyond that.

## Test plan
- **Reset:** hold `rst`=0 mid-WAIT.
  - `mem_req` drops without waiting for a clock edge.
  - All outputs 0.
  - Ack then ignored after release.
- **Load, ack on first cycle:** LW at addr 0x100, Rdes=5, DatatoReg=01; ack with rdata 0x12345678 in cycle 1.
  - `mem_stall` high for 2 cycles.
  - After cycle 2: `WB_RegWrite`=1, `WB_Rdes`=5, `WB_Data`=0x12345678.
- **Store with delayed ack:** store 0xCAFEF00D to 0x40, ack after 3 WAIT cycles.
  - `mem_we`=1, `mem_addr`=0x40 stable for 3 cycles.
  - 4 stall cycles; `WB_RegWrite`=0.
- **Misaligned:** LW at 0x102.
  - No `mem_req`, no stall.
  - `align_err` pulses 1 cycle; `WB_RegWrite`=0.
- **Timeout:** `TIMEOUT`=4, no ack.
  - 4 WAIT cycles, `bus_err` pulse.
  - `WB_Data`=0xDEADBEEF, `WB_RegWrite`=0.
- **Pass-through and back-to-back:**
  - ALU op (DatatoReg=00, ALUOut=7, Rdes=3): WB next cycle, no stall.
  - Two consecutive loads: second `mem_req` rises one cycle after the first DONE.
